ysyx_24100005_wbu_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the single write port of the integer register file. Two producers (port 0: EXU/ALU results, port 1: LSU load data) compete for the one write port through valid/ready handshakes. Accepted writes are registered and driven onto the register file write port. A per-register busy scoreboard, set at issue and cleared at write-back, tells the decode stage when a source operand is still pending.

---
 rtl/ysyx_24100005_wbu_arbiter.sv | 144 ++++++++++++++
 tb/tb_ysyx_24100005_wbu_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_wbu_arbiter.sv
// ysyx_24100005_wbu_arbiter
// Write-back arbiter and busy scoreboard for the single register file
// write port. Port 0 carries EXU/ALU results, port 1 carries LSU load data.
// Accepted writes are registered one cycle and then driven to the register
// file. A per-register busy bit is set when a destination is reserved at
// issue and cleared when its write reaches the register file.
//
// Build option: define WBU_ARB_RR_EN for round-robin arbitration between
// the two producers. Left undefined, port 1 (LSU) has fixed priority.
module ysyx_24100005_wbu_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // issue-stage reservation
    input  logic                  rsv_valid,
    output logic                  rsv_ready,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    // producer 0: EXU/ALU
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    // producer 1: LSU
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    // register file write port
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    // decode-stage source status
    input  logic [ADDR_WIDTH-1:0] rs1addr,
    input  logic [ADDR_WIDTH-1:0] rs2addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic                  prio1;      // port 1 wins when both are valid
    logic                  grant1;
    logic                  fire0;
    logic                  fire1;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  rsv_fire;

    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;

`ifdef WBU_ARB_RR_EN
    // Pointer names the port granted most recently; the other port wins
    // the next contention, so two persistent requesters alternate.
    logic ptr_q;

    assign prio1 = (ptr_q == 1'b0);

    // Track the last granted port on every accepted write.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            ptr_q <= 1'b1;
        end else if (fire) begin
            ptr_q <= fire1;
        end
    end
`else
    // Fixed priority: the LSU always wins contention.
    assign prio1 = 1'b1;
`endif

    // Grant depends only on the valids and the priority state, never on the
    // write stage or the scoreboard, so the producers never stall internally.
    assign grant1     = ~rst & req1_valid & (~req0_valid | prio1);
    assign req1_ready = grant1;
    assign req0_ready = ~rst & req0_valid & ~grant1;

    assign fire0    = req0_valid & req0_ready;
    assign fire1    = req1_valid & req1_ready;
    assign fire     = fire0 | fire1;
    assign win_addr = fire1 ? req1_addr : req0_addr;
    assign win_data = fire1 ? req1_data : req0_data;

    // Register the winning write; x0 writes are accepted but never enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else if (fire) begin
            rf_wen_q   <= (win_addr != '0);
            rf_waddr_q <= win_addr;
            rf_wdata_q <= win_data;
        end else begin
            rf_wen_q   <= 1'b0;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // A destination that is still busy cannot be reserved again (WAW stall).
    assign rsv_ready = ~rst & ((rsv_addr == '0) | ~busy_q[rsv_addr]);
    assign rsv_fire  = rsv_valid & rsv_ready & (rsv_addr != '0);

    // Next scoreboard: clear on commit, then set on reservation so a set to
    // the same register in the same cycle takes precedence.
    always_comb begin
        // NOTE: the full default assignment first keeps every bit driven on
        // every path, so no latch is inferred for busy_d.
        busy_d = busy_q;
        if (rf_wen_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (rsv_fire) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state; cleared wholesale on reset.
    always_ff @(posedge clk) begin
        // NOTE: the scoreboard is a flop vector rather than a RAM, so it can
        // and must be reset; stale busy bits would deadlock issue.
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1addr];
    assign rs2_busy = busy_q[rs2addr];

endmodule

// File: tb/tb_ysyx_24100005_wbu_arbiter.sv
// Self-checking bench for ysyx_24100005_wbu_arbiter. Expected register file
// writes are queued when a fire is predicted and popped when rf_wen appears.
// Works for both the fixed-priority and the WBU_ARB_RR_EN builds.
module tb_ysyx_24100005_wbu_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rsv_valid;
    logic          rsv_ready;
    logic [AW-1:0] rsv_addr;
    logic          req0_valid, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rs1addr, rs2addr;
    logic          rs1_busy, rs2_busy;

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t exp_q[$];
    bit  ptr_m;      // reference: last granted port (round-robin build)

    ysyx_24100005_wbu_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rsv_valid  (rsv_valid),
        .rsv_ready  (rsv_ready),
        .rsv_addr   (rsv_addr),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rs1addr    (rs1addr),
        .rs2addr    (rs2addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Port 1 priority under contention according to the build.
    function automatic bit prio1_m();
`ifdef WBU_ARB_RR_EN
        return (ptr_m == 1'b0);
`else
        return 1'b1;
`endif
    endfunction

    // One clock with the currently driven stimulus: check readies before the
    // edge, queue the predicted write, then step past the edge.
    task automatic do_cycle(input string tag);
        bit g0, g1;
        @(negedge clk);
        g1 = req1_valid && (!req0_valid || prio1_m());
        g0 = req0_valid && !g1;
        check({tag, ".req0_ready"}, 64'(req0_ready), 64'(g0));
        check({tag, ".req1_ready"}, 64'(req1_ready), 64'(g1));
        if (g0 && req0_addr != 0) exp_q.push_back('{addr: req0_addr, data: req0_data});
        if (g1 && req1_addr != 0) exp_q.push_back('{addr: req1_addr, data: req1_data});
        @(posedge clk);
        if (g0) ptr_m = 1'b0;
        else if (g1) ptr_m = 1'b1;
        #1;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Every observed register file write must match the oldest prediction.
    always @(negedge clk) begin
        if (rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rf_wen_unexpected", 64'(rf_wen), 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                check("rf_wdata", 64'(rf_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rsv_valid = 1'b0; rsv_addr = '0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h2;
        rs1addr = '0; rs2addr = '0;
        ptr_m = 1'b1;

        // Reset: nothing is ready while rst is high, even with valids up.
        @(negedge clk);
        rsv_valid = 1'b1; rsv_addr = 5'd6;
        #1;
        check("rst.req0_ready", 64'(req0_ready), 64'd0);
        check("rst.req1_ready", 64'(req1_ready), 64'd0);
        check("rst.rsv_ready",  64'(rsv_ready),  64'd0);
        idle_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0; rsv_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst.rf_wen",   64'(rf_wen),   64'd0);
        check("rst.rf_waddr", 64'(rf_waddr), 64'd0);
        check("rst.rf_wdata", 64'(rf_wdata), 64'd0);
        rs1addr = 5'd6;
        #1;
        check("rst.busy6", 64'(rs1_busy), 64'd0);
        idle_cycle();

        // Reserve x5, then a second reservation of x5 must stall.
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        @(negedge clk);
        check("rsv5.ready", 64'(rsv_ready), 64'd1);
        idle_cycle();
        rs1addr = 5'd5;
        @(negedge clk);
        check("rsv5.rs1_busy", 64'(rs1_busy), 64'd1);
        check("rsv5.again_ready", 64'(rsv_ready), 64'd0);
        idle_cycle();
        rsv_valid = 1'b0;

        // Single write from port 0 to x5; busy drops two cycles after fire.
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        do_cycle("wr5");
        req0_valid = 1'b0;
        @(negedge clk);
        check("wr5.rf_wen", 64'(rf_wen), 64'd1);
        check("wr5.busy_n1", 64'(rs1_busy), 64'd1);
        idle_cycle();
        @(negedge clk);
        check("wr5.busy_n2", 64'(rs1_busy), 64'd0);
        idle_cycle();

        // Write to x0 from port 1: accepted, never enabled, x0 never busy.
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
        do_cycle("x0");
        req1_valid = 1'b0;
        rs1addr = 5'd0; rs2addr = 5'd0;
        @(negedge clk);
        check("x0.rf_wen", 64'(rf_wen), 64'd0);
        check("x0.rs1_busy", 64'(rs1_busy), 64'd0);
        check("x0.rs2_busy", 64'(rs2_busy), 64'd0);
        idle_cycle();

        // Contention for four cycles, then port 0 drains alone.
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_0A01;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_0B02;
        for (int i = 0; i < 4; i++) do_cycle($sformatf("cont%0d", i));
        req1_valid = 1'b0;
        if (!req0_ready) do_cycle("drain0");
        req0_valid = 1'b0;
        idle_cycle();
        idle_cycle();

        // x7 idle; a write to x7 commits in the same cycle x7 is reserved,
        // and the reservation must survive.
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
        do_cycle("wr7");
        req0_valid = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        @(negedge clk);
        check("setwins.rf_wen", 64'(rf_wen), 64'd1);
        check("setwins.rsv_ready", 64'(rsv_ready), 64'd1);
        idle_cycle();
        rsv_valid = 1'b0;
        rs2addr = 5'd7;
        @(negedge clk);
        check("setwins.busy7", 64'(rs2_busy), 64'd1);
        idle_cycle();

        // Reserve x9 and fire x9, then reset in the following cycle.
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0999;
        do_cycle("midrst.fire");
        rsv_valid = 1'b0; req0_valid = 1'b0;
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        ptr_m = 1'b1;
        rs1addr = 5'd7; rs2addr = 5'd9;
        @(negedge clk);
        check("midrst.rf_wen", 64'(rf_wen), 64'd0);
        check("midrst.busy7", 64'(rs1_busy), 64'd0);
        check("midrst.busy9", 64'(rs2_busy), 64'd0);
        idle_cycle();

        // Priority state back at reset value: observe who wins contention.
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0C03;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_0D04;
        do_cycle("postrst");
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle_cycle();
        idle_cycle();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
